// File: rtl/seg7_scan_ctrl_pkg.sv
// rtl/seg7_scan_ctrl_pkg.sv - shared constants, segment type and hex glyph table
package seg7_pkg;

   localparam int NUM_DIGITS = 8;

   typedef logic [6:0] seg7_t;

   localparam seg7_t      SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   // Active-low segments, A on bit 6 down to G on bit 0.
   function automatic seg7_t hex_glyph(input logic [3:0] nibble);
      seg7_t g;
      case (nibble)
         4'h0: g = 7'b0000001;
         4'h1: g = 7'b1001111;
         4'h2: g = 7'b0010010;
         4'h3: g = 7'b0000110;
         4'h4: g = 7'b1001100;
         4'h5: g = 7'b0100100;
         4'h6: g = 7'b0100000;
         4'h7: g = 7'b0001111;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0000100;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b1100000;
         4'hC: g = 7'b0110001;
         4'hD: g = 7'b1000010;
         4'hE: g = 7'b0110000;
         default: g = 7'b0111000;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - valid/ready load port carrying the 32-bit display value
interface seg7_scan_ctrl_if;

   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;

   modport master (output load_valid, output load_data, input  load_ready);
   modport slave  (input  load_valid, input  load_data, output load_ready);

endinterface

// File: rtl/seg7_scan_ctrl_decode.sv
// rtl/seg7_scan_ctrl_decode.sv - combinational nibble to active-low segment decoder
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] i_nibble,
   output seg7_t      o_seg
);

   assign o_seg = hex_glyph(i_nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 8-digit seven-segment scan controller with frame-aligned loads
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
)
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   seg7_scan_ctrl_if.slave      lif,
   input  logic [7:0]           i_dp_in,
   input  logic [7:0]           i_digit_en,
   output seg7_t                o_seg,
   output logic                 o_dp,
   output logic [7:0]           o_an,
   output logic                 o_frame_tick
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] PCNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [CW-1:0] r_pcnt;
   logic [IW-1:0] r_idx;
   logic [31:0]   r_cur;
   logic [31:0]   r_pend_data;
   logic          r_pend;
   logic          r_blank;

   logic          w_tick;
   logic          w_wrap;
   logic          w_xfer;
   logic [3:0]    w_nibble;
   logic [31:0]   w_upper;
   logic          w_lz_ok;
   logic          w_show;
   logic [7:0]    w_an_sel;
   seg7_t         w_seg;

   assign w_tick   = (r_pcnt == PCNT_MAX);
   assign w_wrap   = w_tick && (r_idx == IDX_LAST);
   assign w_xfer   = lif.load_valid && !r_pend;
   assign w_nibble = r_cur[{r_idx, 2'b00} +: 4];
   assign w_upper  = r_cur >> {r_idx, 2'b00};
   assign w_an_sel = ~(8'd1 << r_idx);

`ifdef SEG7_LZ_BLANK_EN
   assign w_lz_ok  = (r_idx == '0) || (w_upper != 32'd0);
`else
   assign w_lz_ok  = 1'b1;
`endif

   assign w_show          = i_digit_en[r_idx] && w_lz_ok;
   assign lif.load_ready  = !r_pend;

   seg7_decode u_decode (
      .i_nibble (w_nibble),
      .o_seg    (w_seg)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pcnt  <= '0;
         r_idx   <= '0;
         r_blank <= 1'b1;
      end else begin
         r_pcnt  <= w_tick ? '0 : r_pcnt + 1'b1;
         r_idx   <= w_tick ? r_idx + 1'b1 : r_idx;
         r_blank <= w_tick;
      end
   end

   // A value offered on the wrap edge itself skips the pending stage.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cur       <= '0;
         r_pend_data <= '0;
         r_pend      <= 1'b0;
      end else if (w_wrap) begin
         if (r_pend) begin
            r_cur  <= r_pend_data;
            r_pend <= 1'b0;
         end else if (w_xfer) begin
            r_cur  <= lif.load_data;
         end
      end else if (w_xfer) begin
         r_pend_data <= lif.load_data;
         r_pend      <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_an         <= AN_OFF;
         o_seg        <= SEG_OFF;
         o_dp         <= 1'b1;
         o_frame_tick <= 1'b0;
      end else begin
         o_frame_tick <= w_wrap;
         if (r_blank) begin
            o_an  <= AN_OFF;
            o_seg <= SEG_OFF;
            o_dp  <= 1'b1;
         end else begin
            o_an  <= w_show ? w_an_sel : AN_OFF;
            o_seg <= w_seg;
            o_dp  <= !i_dp_in[r_idx];
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl with cycle-count reference model
module tb_seg7_scan_ctrl;

   localparam int DIV   = 4;
   localparam int FRAME = 8 * DIV;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] dp_in;
   logic [7:0] digit_en;
   logic [6:0] seg;
   logic       dp;
   logic [7:0] an;
   logic       frame_tick;

   seg7_scan_ctrl_if lif ();

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .lif          (lif),
      .i_dp_in      (dp_in),
      .i_digit_en   (digit_en),
      .o_seg        (seg),
      .o_dp         (dp),
      .o_an         (an),
      .o_frame_tick (frame_tick)
   );

   int total = 0;
   int bad   = 0;

   int          n;
   logic [31:0] m_cur;
   logic [31:0] m_pdata;
   bit          m_pend;
   logic [6:0]  glyph [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   // One clock: predict outputs from elapsed-cycle arithmetic, advance, compare.
   task automatic cycle();
      int         slot;
      int         idx;
      bit         blank;
      bit         wrap;
      bit         lz;
      bit         xfer;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic [3:0] nib;
      slot  = n % FRAME;
      idx   = slot / DIV;
      blank = (slot % DIV) == 0;
      wrap  = (slot == FRAME - 1);
      nib   = m_cur[4*idx +: 4];
      lz    = 1'b1;
`ifdef SEG7_LZ_BLANK_EN
      lz    = (idx == 0) || ((m_cur >> (4*idx)) != 32'd0);
`endif
      if (blank) begin
         e_an  = 8'hFF;
         e_seg = 7'h7F;
         e_dp  = 1'b1;
      end else begin
         e_an  = (digit_en[idx] && lz) ? ~(8'd1 << idx) : 8'hFF;
         e_seg = glyph[nib];
         e_dp  = !dp_in[idx];
      end
      chk("load_ready", {31'd0, lif.load_ready}, {31'd0, !m_pend});
      xfer = lif.load_valid && !m_pend;
      if (wrap) begin
         if (m_pend) begin
            m_cur  = m_pdata;
            m_pend = 1'b0;
         end else if (xfer) begin
            m_cur  = lif.load_data;
         end
      end else if (xfer) begin
         m_pdata = lif.load_data;
         m_pend  = 1'b1;
      end
      n++;
      @(posedge clk);
      @(negedge clk);
      chk("an", {24'd0, an}, {24'd0, e_an});
      chk("seg", {25'd0, seg}, {25'd0, e_seg});
      chk("dp", {31'd0, dp}, {31'd0, e_dp});
      chk("frame_tick", {31'd0, frame_tick}, {31'd0, wrap});
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_an", {24'd0, an}, 32'hFF);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_dp", {31'd0, dp}, 32'd1);
      chk("rst_ft", {31'd0, frame_tick}, 32'd0);
      chk("rst_ready", {31'd0, lif.load_ready}, 32'd1);
      @(negedge clk);
      rst_n   = 1'b1;
      n       = 0;
      m_cur   = '0;
      m_pdata = '0;
      m_pend  = 1'b0;
   endtask

   initial begin
      int k;
      glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      n              = 0;
      m_cur          = '0;
      m_pdata        = '0;
      m_pend         = 1'b0;
      lif.load_valid = 1'b0;
      lif.load_data  = '0;
      dp_in          = 8'h00;
      digit_en       = 8'hFF;
      rst_n          = 1'b0;
      @(negedge clk);
      do_reset();

      // Idle frame: anode walk with one blank cycle per slot.
      repeat (FRAME + 2) cycle();

      // Mid-frame load: held in pend until the wrap.
      repeat (6) cycle();
      lif.load_valid = 1'b1;
      lif.load_data  = 32'h8765_4321;
      cycle();
      lif.load_valid = 1'b0;
      chk("ready_drop", {31'd0, lif.load_ready}, 32'd0);
      k = 0;
      while (frame_tick !== 1'b1 && k < 2 * FRAME) begin cycle(); k++; end
      chk("ft_seen", {31'd0, frame_tick}, 32'd1);
      cycle();
      cycle();
      chk("digit0_seg", {25'd0, seg}, {25'd0, 7'b1001111});
      chk("digit0_an", {24'd0, an}, 32'hFE);
      repeat (28) cycle();
      chk("digit7_seg", {25'd0, seg}, 32'd0);
      chk("digit7_an", {24'd0, an}, 32'h7F);
      chk("ready_back", {31'd0, lif.load_ready}, 32'd1);

      // Second load held while pend is set: accepted after the wrap.
      repeat (5) cycle();
      lif.load_valid = 1'b1;
      lif.load_data  = 32'h1234_5678;
      cycle();
      lif.load_data  = 32'h9ABC_DEF0;
      k = 0;
      while (lif.load_ready !== 1'b1 && k < 2 * FRAME) begin cycle(); k++; end
      chk("accept_after_wrap", {31'd0, frame_tick}, 32'd1);
      cycle();
      lif.load_valid = 1'b0;
      repeat (2 * FRAME + 3) cycle();

      // Transfer on the wrap edge with nothing pending.
      k = 0;
      while ((n % FRAME) != FRAME - 1 && k < 2 * FRAME) begin cycle(); k++; end
      lif.load_valid = 1'b1;
      lif.load_data  = 32'hFFFF_FFFF;
      cycle();
      lif.load_valid = 1'b0;
      chk("wrap_xfer_ft", {31'd0, frame_tick}, 32'd1);
      cycle();
      cycle();
      chk("wrap_xfer_seg", {25'd0, seg}, {25'd0, 7'b0111000});
      repeat (FRAME) cycle();

      // Digit enable and decimal point gating.
      digit_en = 8'h0F;
      dp_in    = 8'h01;
      repeat (FRAME + 4) cycle();

      // Random traffic.
      for (int i = 0; i < 200; i++) begin
         lif.load_valid = ($urandom_range(0, 3) == 0);
         lif.load_data  = $urandom;
         digit_en       = 8'($urandom);
         dp_in          = 8'($urandom);
         cycle();
      end
      lif.load_valid = 1'b0;
      digit_en       = 8'hFF;
      dp_in          = 8'h00;
      repeat (FRAME) cycle();

      // Reset while a value is pending discards it.
      k = 0;
      while ((n % FRAME) != 5 && k < 2 * FRAME) begin cycle(); k++; end
      lif.load_valid = 1'b1;
      lif.load_data  = 32'h5555_5555;
      cycle();
      lif.load_valid = 1'b0;
      chk("pend_before_rst", {31'd0, lif.load_ready}, 32'd0);
      do_reset();
      repeat (FRAME + 4) cycle();
      lif.load_valid = 1'b1;
      lif.load_data  = 32'h0000_00A5;
      cycle();
      lif.load_valid = 1'b0;
      repeat (2 * FRAME + 4) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing scan controller for the 8-digit, active-low seven-segment display on the board. It takes a 32-bit hex value (8 nibbles) through a valid/ready load port and sequences the eight anodes at a programmable refresh rate. For the selected digit it drives that digit's nibble through the hex-to-segment decoder. New values are applied only at frame boundaries, so a frame never shows a mix of old and new data.

## Interface
- REFRESH_DIV, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2 to 2^20.
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a value; equals NOT pend.
- load_data  input  32  nibble i (bits 4i+3:4i) is displayed on digit i.
- dp_in  input  8  decimal point request per digit, active-high, sampled live.
- digit_en  input  8  per-digit enable, active-high, sampled live.
- seg  output  7  segments A..G on seg[6]..seg[0], active-low.
- dp  output  1  decimal point, active-low.
- an  output  8  anodes, active-low, at most one low at a time.
- frame_tick  output  1  one-cycle pulse on each frame wrap.

## Operation
- State:
  - prescaler pcnt, 0..REFRESH_DIV-1
  - digit index idx, 3 bits
  - cur (32 bits, the displayed value)
  - pend_data (32 bits) and the pend flag
  - blank flag
- tick is asserted when pcnt == REFRESH_DIV-1. On tick, pcnt goes to 0 and idx increments modulo 8.
- wrap = tick AND idx == 7.
- Handshake:
  - A transfer occurs when load_valid AND load_ready. load_ready is high only when pend == 0.
  - On a transfer in a non-wrap cycle: pend_data <= load_data and pend <= 1.
  - On wrap with pend == 1: cur <= pend_data and pend <= 0.
  - On wrap with a simultaneous transfer (pend == 0): cur <= load_data directly and pend stays 0.
  - load_valid held with no transfer has no effect.
- Digit gating: slot i shows an = all 1s when digit_en[i] == 0. The slot is still consumed, so per-digit duty stays fixed at 1/8.
- Anti-ghosting: for the first cycle of every slot (the cycle after tick, blank == 1), an = 8'hFF and seg and dp are off.
- Otherwise an = ~(1 << idx), seg = decode(cur nibble idx), dp = ~dp_in[idx].
- Decoder uses standard hex glyphs 0-F:
  - 0 → 7'b0000001
  - 1 → 7'b1001111
  - 8 → 7'b0000000
  - A → 7'b0001000

## Timing
- Reset values:
  - pcnt = 0, idx = 0, cur = 0, pend = 0, blank = 1.
  - an = 8'hFF, seg = 7'h7F, dp = 1, frame_tick = 0, load_ready = 1.
- Assertion of rst_n low at any time returns all state to reset values immediately. A pending value is discarded.
- seg, dp, an and frame_tick are registered. Outputs reflect idx, cur, digit_en and dp_in with 1-cycle latency.
- frame_tick is high in the cycle after wrap, which is the same cycle cur's new value first becomes visible in state.
- Digit 0 is lit starting 2 cycles after the wrap edge: 1 blank cycle, then the register stage.
- Load-to-display latency: at most 8*REFRESH_DIV + 2 cycles.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking.
  - A digit i > 0 is forced off (an bit high) when nibbles 7..i of cur are all zero.
  - Digit 0 is always shown (subject to digit_en).
  - Example: cur = 32'h0000_00A5 lights digits 1 and 0 only.
- Macro undefined: every enabled digit is displayed, including leading zeros.

## Structure
- Package seg7_pkg holds:
  - NUM_DIGITS = 8
  - SEG_OFF = 7'h7F
  - AN_OFF = 8'hFF
  - the seg7_t typedef (logic [6:0])
  - function hex_glyph(nibble) returning seg7_t
- One sub-module, seg7_decode: purely combinational, 4-bit nibble in, 7-bit active-low segments out.
- The scan FSM, prescaler and load registers stay in seg7_scan_ctrl.

## Test plan
All scenarios use REFRESH_DIV = 4.
- Reset: rst_n low → an = FF, seg = 7F, dp = 1, load_ready = 1. After release, an walks FE, FD, … 7F, and each slot opens with exactly 1 cycle of an = FF.
- Load 32'h8765_4321 mid-frame:
  - load_ready drops the next cycle.
  - Digits still show 0 until frame_tick.
  - Then digit 0 shows 7'b1001111 and digit 7 shows 7'b0000000.
  - load_ready returns to 1.
- Second load while pend = 1: load_valid is held but no transfer occurs. It is accepted on the cycle after the wrap, and the first value is displayed for a full frame.
- Transfer in the wrap cycle with pend = 0: value 32'hFFFF_FFFF appears in the frame that starts immediately (next frame_tick not required).
- digit_en = 8'h0F with dp_in = 8'h01: digits 4-7 keep an bit high, and dp = 0 only in slot 0.
- rst_n pulsed low during pend = 1: pending value is lost. With SEG7_LZ_BLANK_EN defined, a load of 32'h0000_00A5 lights only an = FE and FD.
